// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: FSM encoding, SYSCALL
// service codes and register indices.
package wb_stage_pkg;

   // Write-back FSM state encoding
   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_PAUSE  = 2'd1;
   localparam logic [1:0] ST_HALT   = 2'd2;
   localparam logic [1:0] ST_RESUME = 2'd3;

   // SYSCALL service codes carried in $v0
   localparam int unsigned HALT_CODE_DEF = 10;
   localparam int unsigned DISP_CODE_DEF = 34;

   // Link register written by JAL
   localparam logic [4:0] REG_RA   = 5'd31;
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Return address for JAL; wraps modulo 2^32
   function automatic logic [31:0] link_addr(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline register outputs plus the register-file write port.
// master: the pipeline side driving MEM/WB and receiving the write port.
// slave:  the write-back stage.
interface wb_stage_if;

   logic [31:0] IR;
   logic [31:0] PC;
   logic [31:0] R1;
   logic [31:0] R2;
   logic [31:0] RD1;
   logic [31:0] RD2;
   logic [4:0]  WbRegNum;
   logic        RegWrite;
   logic        LOWrite;
   logic        HIWrite;
   logic        JAL;
   logic        SYSCALL;

   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   modport master (
      output IR, PC, R1, R2, RD1, RD2, WbRegNum,
      output RegWrite, LOWrite, HIWrite, JAL, SYSCALL,
      input  rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  IR, PC, R1, R2, RD1, RD2, WbRegNum,
      input  RegWrite, LOWrite, HIWrite, JAL, SYSCALL,
      output rf_we, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/wb_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;
   logic         full;

   assign full = (q_q == '1);

   // Next value: clear wins, otherwise step unless already saturated
   always_comb begin
      q_d = q_q;
      if (clear) begin
         q_d = '0;
      end else if (inc && !full) begin
         q_d = q_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: register-file write port, HI/LO ownership, SYSCALL
// handling via a RUN/PAUSE/HALT/RESUME machine, and statistics counters.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned HALT_CODE = HALT_CODE_DEF,
   parameter int unsigned DISP_CODE = DISP_CODE_DEF
) (
   input  logic             clk,
   input  logic             CLR_n,
   wb_stage_if.slave        wb,
   input  logic             go,
   output logic [31:0]      HI,
   output logic [31:0]      LO,
   output logic [31:0]      disp,
   output logic             stall,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] sys_cnt
);

   logic [1:0]  state_q, state_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] disp_q, disp_d;

   logic in_run;
   logic act;
   logic sys_acc;
   logic is_halt;
   logic is_disp;
   logic clr;
   logic instr_inc;

   assign in_run    = (state_q == ST_RUN);
   // RESUME still retires the frozen instruction's non-SYSCALL effects;
   // only the SYSCALL itself is masked so it cannot retrigger a pause.
   assign act       = in_run || (state_q == ST_RESUME);
   assign sys_acc   = in_run && wb.SYSCALL;
   assign is_halt   = (wb.RD1 == HALT_CODE);
   assign is_disp   = (wb.RD1 == DISP_CODE);
   assign clr       = ~CLR_n;
   assign instr_inc = act && (wb.IR != '0);

   // Register-file write port, zero latency
   always_comb begin
      wb.rf_we    = wb.RegWrite && act && (wb.WbRegNum != REG_ZERO);
      wb.rf_waddr = wb.WbRegNum;
      wb.rf_wdata = wb.JAL ? link_addr(wb.PC) : wb.R1;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (wb.SYSCALL) begin
               if (is_halt) begin
                  state_d = ST_HALT;
               end else if (!is_disp) begin
                  state_d = ST_PAUSE;
               end
            end
         end
         ST_PAUSE: begin
            if (go) begin
               state_d = ST_RESUME;
            end
         end
         ST_HALT:   state_d = ST_HALT;
         ST_RESUME: state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase
   end

   // HI/LO and display register next values
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      disp_d = disp_q;
      if (act && wb.HIWrite) begin
         hi_d = wb.R2;
      end
      if (act && wb.LOWrite) begin
         lo_d = wb.R1;
      end
      if (sys_acc && is_disp) begin
         disp_d = wb.RD2;
      end
   end

   // State and architectural registers; reset overrides everything
   always_ff @(posedge clk) begin
      if (!CLR_n) begin
         state_q <= ST_RUN;
         hi_q    <= '0;
         lo_q    <= '0;
         disp_q  <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         disp_q  <= disp_d;
      end
   end

   assign HI     = hi_q;
   assign LO     = lo_q;
   assign disp   = disp_q;
   assign stall  = (state_q == ST_PAUSE) || (state_q == ST_HALT);
   assign halted = (state_q == ST_HALT);

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .clear (clr),
      .inc   (act),
      .q     (cycle_cnt)
   );

   sat_counter #(.W(CNT_W)) u_instr_cnt (
      .clk   (clk),
      .clear (clr),
      .inc   (instr_inc),
      .q     (instr_cnt)
   );

   sat_counter #(.W(CNT_W)) u_sys_cnt (
      .clk   (clk),
      .clear (clr),
      .inc   (sys_acc),
      .q     (sys_cnt)
   );

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (counters narrowed to 8 bits
// so saturation is reachable quickly).
module tb_wb_stage;
   import wb_stage_pkg::*;

   localparam int unsigned CW = 8;

   logic          clk;
   logic          CLR_n;
   logic          go;
   logic [31:0]   HI, LO, disp;
   logic          stall, halted;
   logic [CW-1:0] cycle_cnt, instr_cnt, sys_cnt;

   int checks;
   int failures;

   wb_stage_if wb ();

   wb_stage #(
      .CNT_W     (CW),
      .HALT_CODE (10),
      .DISP_CODE (34)
   ) dut (
      .clk       (clk),
      .CLR_n     (CLR_n),
      .wb        (wb),
      .go        (go),
      .HI        (HI),
      .LO        (LO),
      .disp      (disp),
      .stall     (stall),
      .halted    (halted),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt),
      .sys_cnt   (sys_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
      end
      #1;
   endtask

   task automatic idle();
      wb.IR       = '0;
      wb.PC       = '0;
      wb.R1       = '0;
      wb.R2       = '0;
      wb.RD1      = '0;
      wb.RD2      = '0;
      wb.WbRegNum = '0;
      wb.RegWrite = 1'b0;
      wb.LOWrite  = 1'b0;
      wb.HIWrite  = 1'b0;
      wb.JAL      = 1'b0;
      wb.SYSCALL  = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Reset with random inputs
      CLR_n       = 1'b0;
      go          = 1'($urandom);
      wb.IR       = $urandom;
      wb.PC       = $urandom;
      wb.R1       = $urandom;
      wb.R2       = $urandom;
      wb.RD1      = 32'd10;
      wb.RD2      = $urandom;
      wb.WbRegNum = 5'($urandom);
      wb.RegWrite = 1'($urandom);
      wb.LOWrite  = 1'b1;
      wb.HIWrite  = 1'b1;
      wb.JAL      = 1'($urandom);
      wb.SYSCALL  = 1'b1;
      tick(2);
      chk("rst_hi", HI, 32'h0);
      chk("rst_lo", LO, 32'h0);
      chk("rst_disp", disp, 32'h0);
      chk("rst_cyc", 32'(cycle_cnt), 32'd0);
      chk("rst_instr", 32'(instr_cnt), 32'd0);
      chk("rst_sys", 32'(sys_cnt), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);

      // JAL link write
      CLR_n = 1'b1;
      go    = 1'b0;
      idle();
      wb.IR       = 32'h0C10_0004;
      wb.PC       = 32'h0040_0010;
      wb.R1       = 32'h0000_DEAD;
      wb.JAL      = 1'b1;
      wb.RegWrite = 1'b1;
      wb.WbRegNum = REG_RA;
      #1;
      chk("jal_we", 32'(wb.rf_we), 32'd1);
      chk("jal_waddr", 32'(wb.rf_waddr), 32'd31);
      chk("jal_wdata", wb.rf_wdata, 32'h0040_0014);
      wb.WbRegNum = 5'd0;
      #1;
      chk("r0_we", 32'(wb.rf_we), 32'd0);
      wb.WbRegNum = 5'd9;
      wb.JAL      = 1'b0;
      #1;
      chk("alu_wdata", wb.rf_wdata, 32'h0000_DEAD);
      wb.JAL = 1'b1;
      wb.PC  = 32'hFFFF_FFFC;
      #1;
      chk("jal_wrap", wb.rf_wdata, 32'h0000_0000);
      tick(1);
      chk("e1_cyc", 32'(cycle_cnt), 32'd1);
      chk("e1_instr", 32'(instr_cnt), 32'd1);

      // Mult: both HI and LO
      idle();
      wb.IR      = 32'h0200_0018;
      wb.R1      = 32'h0000_1234;
      wb.R2      = 32'hFFFF_FFFF;
      wb.LOWrite = 1'b1;
      wb.HIWrite = 1'b1;
      tick(1);
      chk("mult_lo", LO, 32'h0000_1234);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_instr", 32'(instr_cnt), 32'd2);

      // LO only
      wb.R1      = 32'h0000_0055;
      wb.R2      = 32'h0000_0077;
      wb.HIWrite = 1'b0;
      tick(1);
      chk("mtlo_lo", LO, 32'h0000_0055);
      chk("mtlo_hi", HI, 32'hFFFF_FFFF);

      // Bubble does not retire
      idle();
      tick(1);
      chk("bub_instr", 32'(instr_cnt), 32'd3);
      chk("bub_cyc", 32'(cycle_cnt), 32'd4);

      // Display syscall
      wb.IR      = 32'h0000_000C;
      wb.SYSCALL = 1'b1;
      wb.RD1     = 32'd34;
      wb.RD2     = 32'h0000_CAFE;
      tick(1);
      chk("disp_val", disp, 32'h0000_CAFE);
      chk("disp_stall", 32'(stall), 32'd0);
      chk("disp_sys", 32'(sys_cnt), 32'd1);
      chk("disp_instr", 32'(instr_cnt), 32'd4);

      // Pausing syscall, with a register write in the same cycle
      wb.RD1      = 32'd5;
      wb.RD2      = 32'h0000_1111;
      wb.RegWrite = 1'b1;
      wb.WbRegNum = 5'd3;
      wb.R1       = 32'h0000_ABCD;
      #1;
      chk("sysw_we", 32'(wb.rf_we), 32'd1);
      tick(1);
      chk("pause_stall", 32'(stall), 32'd1);
      chk("pause_halted", 32'(halted), 32'd0);
      chk("pause_sys", 32'(sys_cnt), 32'd2);
      chk("pause_cyc", 32'(cycle_cnt), 32'd6);
      chk("pause_disp", disp, 32'h0000_CAFE);
      wb.LOWrite = 1'b1;
      wb.R1      = 32'h0000_9999;
      #1;
      chk("pause_we", 32'(wb.rf_we), 32'd0);
      tick(5);
      chk("hold_stall", 32'(stall), 32'd1);
      chk("hold_cyc", 32'(cycle_cnt), 32'd6);
      chk("hold_instr", 32'(instr_cnt), 32'd5);
      chk("hold_sys", 32'(sys_cnt), 32'd2);
      chk("hold_lo", LO, 32'h0000_0055);

      // Resume: one RESUME cycle, frozen SYSCALL ignored
      go = 1'b1;
      tick(1);
      go = 1'b0;
      chk("resume_stall", 32'(stall), 32'd0);
      #1;
      chk("resume_we", 32'(wb.rf_we), 32'd1);
      tick(1);
      chk("run_stall", 32'(stall), 32'd0);
      chk("run_lo", LO, 32'h0000_9999);
      chk("run_sys", 32'(sys_cnt), 32'd2);
      chk("run_cyc", 32'(cycle_cnt), 32'd7);
      chk("run_instr", 32'(instr_cnt), 32'd6);

      // go in RUN has no effect
      idle();
      go = 1'b1;
      tick(1);
      chk("gorun_stall", 32'(stall), 32'd0);
      go = 1'b0;
      tick(1);
      chk("gorun2_stall", 32'(stall), 32'd0);
      chk("gorun_cyc", 32'(cycle_cnt), 32'd9);

      // Halt syscall
      wb.IR      = 32'h0000_000C;
      wb.SYSCALL = 1'b1;
      wb.RD1     = 32'd10;
      tick(1);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_stall", 32'(stall), 32'd1);
      chk("halt_sys", 32'(sys_cnt), 32'd3);
      chk("halt_cyc", 32'(cycle_cnt), 32'd10);
      wb.SYSCALL  = 1'b0;
      wb.IR       = 32'h0000_1234;
      wb.RegWrite = 1'b1;
      wb.WbRegNum = 5'd7;
      go          = 1'b1;
      #1;
      chk("halt_we", 32'(wb.rf_we), 32'd0);
      tick(3);
      chk("halt2_halted", 32'(halted), 32'd1);
      chk("halt2_stall", 32'(stall), 32'd1);
      chk("halt2_cyc", 32'(cycle_cnt), 32'd10);
      chk("halt2_instr", 32'(instr_cnt), 32'd7);

      // Reset out of HALT
      CLR_n = 1'b0;
      tick(1);
      chk("rst2_halted", 32'(halted), 32'd0);
      chk("rst2_stall", 32'(stall), 32'd0);
      chk("rst2_cyc", 32'(cycle_cnt), 32'd0);
      chk("rst2_lo", LO, 32'h0);
      chk("rst2_disp", disp, 32'h0);

      // Counter saturation
      CLR_n = 1'b1;
      go    = 1'b0;
      idle();
      wb.IR = 32'h0000_1234;
      tick(254);
      chk("sat_cyc_254", 32'(cycle_cnt), 32'd254);
      chk("sat_instr_254", 32'(instr_cnt), 32'd254);
      tick(1);
      chk("sat_cyc_255", 32'(cycle_cnt), 32'd255);
      tick(5);
      chk("sat_cyc_hold", 32'(cycle_cnt), 32'd255);
      chk("sat_instr_hold", 32'(instr_cnt), 32'd255);
      chk("sat_sys", 32'(sys_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the pipelined CPU, consuming the MEM/WB pipeline register outputs. It drives the register-file write port, owns the HI/LO registers, and executes SYSCALL through a RUN/PAUSE/HALT state machine that stalls the pipeline. It also keeps cycle, retired-instruction and syscall counters for the debug display.

## Interface
Parameters:
- CNT_W, 32: width of each statistics counter.
- HALT_CODE, 10: $v0 value that halts the CPU.
- DISP_CODE, 34: $v0 value that latches $a0 into the display register.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- CLR_n  in  1  reset, synchronous, active-low.
- IR, PC  in  32 each  instruction word and its address; IR==0 marks a bubble.
- R1  in  32  primary result (ALU result or load data, muxed upstream).
- R2  in  32  secondary result (high word of mult/div).
- RD1, RD2  in  32 each  register read data ($v0, $a0 for SYSCALL).
- WbRegNum  in  5  destination register.
- RegWrite, LOWrite, HIWrite, JAL, SYSCALL  in  1 each  write-back control bits.
- go  in  1  resume pulse from the debug panel.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- HI, LO  out  32 each  HI/LO registers.
- disp  out  32  display register.
- stall  out  1  freeze request to all upstream EN inputs.
- halted  out  1  high in HALT.
- cycle_cnt, instr_cnt, sys_cnt  out  CNT_W each  statistics counters.

## Operation
- "act" means state==RUN, or state==RESUME for non-SYSCALL effects. In RESUME, SYSCALL is ignored.
- Register-file write port (combinational):
  - rf_we = RegWrite & act & (WbRegNum!=0).
  - rf_waddr = WbRegNum.
  - rf_wdata = JAL ? PC+4 : R1. PC+4 wraps modulo 2^32.
- HI/LO:
  - LOWrite & act: LO <= R1.
  - HIWrite & act: HI <= R2.
  - Both asserted in one cycle (mult/div): both update in that cycle.
- States:
  - RUN.
  - PAUSE: stall=1, inputs ignored.
  - HALT: stall=1, halted=1, terminal until reset.
  - RESUME: stall=0, one cycle.
- Transitions:
  - In RUN, SYSCALL with RD1==HALT_CODE goes to HALT.
  - In RUN, SYSCALL with RD1==DISP_CODE sets disp <= RD2 and stays in RUN.
  - In RUN, SYSCALL with any other RD1 goes to PAUSE.
  - PAUSE goes to RESUME when go=1. A go pulse in RUN, RESUME or HALT has no effect.
  - RESUME always goes to RUN.
- RESUME exists because the frozen SYSCALL is still in MEM/WB during the first unstalled cycle; ignoring it there prevents a retrigger.
- stall is combinational from state, asserted in PAUSE and HALT only.
- Counters saturate at all-ones and never wrap:
  - cycle_cnt: +1 every cycle in RUN or RESUME.
  - instr_cnt: +1 per cycle with act & IR!=0 (bubbles and PAUSE/HALT cycles do not count).
  - sys_cnt: +1 per SYSCALL accepted in RUN.

## Timing
- Reset (CLR_n=0 at an edge) puts state in RUN and clears HI, LO, disp and all counters. Reset overrides every other input in that cycle, including mid-PAUSE or mid-HALT.
- Register-file write is zero latency: it commits at the same edge that updates MEM/WB's successor. HI/LO/disp/counters update at the edge ending the cycle the instruction is in WB.
- SYSCALL accepted in cycle t: stall is high from cycle t+1. Its counter and disp effects land at edge t.
- Resume path: go=1 sampled at edge t gives RESUME in t+1 (stall low) and RUN in t+2.
- SYSCALL in the same cycle as RegWrite: the register write still happens. A SYSCALL instruction carries RegWrite=0.

## Structure
- Shared package holds the state encoding (RUN=0, PAUSE=1, HALT=2, RESUME=3), HALT_CODE/DISP_CODE defaults and the $ra index 31.
- One sub-module, sat_counter (parameter W; inputs inc and clear; output q), instantiated three times.
- The state machine and HI/LO logic stay in wb_stage.

## Test plan
- Reset: hold CLR_n=0 for 2 cycles with random inputs -> HI=LO=disp=0, all counters 0, stall=0, halted=0.
- JAL: PC=0x0040_0010, JAL=1, RegWrite=1, WbRegNum=31 -> rf_we=1, rf_waddr=31, rf_wdata=0x0040_0014. With WbRegNum=0 -> rf_we=0.
- Mult: R1=0x1234, R2=0xFFFF_FFFF, LOWrite=HIWrite=1 -> next cycle LO=0x1234, HI=0xFFFF_FFFF. instr_cnt increments by 1.
- Display syscall: SYSCALL, RD1=34, RD2=0xCAFE -> disp=0xCAFE, stall stays 0, sys_cnt=1.
- Pause and resume:
  - SYSCALL with RD1=5 -> stall=1 next cycle.
  - Hold inputs for 5 cycles -> counters frozen, no rf_we.
  - Pulse go -> exactly one RESUME cycle with stall=0, then RUN, no second PAUSE.
- Halt: SYSCALL with RD1=10 -> halted=1 and stall=1 forever, go ignored, RegWrite inputs give rf_we=0. Asserting CLR_n=0 returns to RUN.
